// File: rtl/zest_spi_sched_pkg.sv
// rtl/zest_spi_sched_pkg.sv - shared types and constants for the Zest P2 SPI scheduler
package zest_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      LATCH = 3'd4,
      GAP   = 3'd5
   } state_e;

   localparam int TGT_U1  = 0;
   localparam int TGT_U2  = 1;
   localparam int TGT_U3  = 2;
   localparam int TGT_U4  = 3;
   localparam int LEN_MIN = 8;
   localparam int LEN_MAX = 32;

   function automatic logic [5:0] clamp_len(input logic [5:0] len);
      if (len < 6'(LEN_MIN)) return 6'(LEN_MIN);
      if (len > 6'(LEN_MAX)) return 6'(LEN_MAX);
      return len;
   endfunction

endpackage

// File: rtl/zest_spi_sched_if.sv
// rtl/zest_spi_sched_if.sv - host-side request/response bundle of the SPI scheduler
interface zest_spi_sched_if #(
   parameter int NT      = 4,
   parameter int RD_BITS = 8
);
   localparam int IW = (NT > 1) ? $clog2(NT) : 1;

   logic [NT-1:0]      req;
   logic [NT-1:0]      req_rd;
   logic [NT*6-1:0]    req_len;
   logic [NT*32-1:0]   req_wdata;
   logic [NT-1:0]      ack;
   logic               done;
   logic [IW-1:0]      done_id;
   logic [RD_BITS-1:0] rdata;
   logic               busy;

   modport master (
      output req, req_rd, req_len, req_wdata,
      input  ack, done, done_id, rdata, busy
   );

   modport slave (
      input  req, req_rd, req_len, req_wdata,
      output ack, done, done_id, rdata, busy
   );
endinterface

// File: rtl/zest_spi_sched_rr_arb.sv
// rtl/zest_spi_sched_rr_arb.sv - NT-wide round-robin arbiter, pointer moves past each grant
module zest_rr_arb
   import zest_spi_pkg::*;
#(
   parameter int NT = 4,
   parameter int IW = (NT > 1) ? $clog2(NT) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NT-1:0] i_req,
   input  logic          i_advance,
   output logic [NT-1:0] o_grant,
   output logic [IW-1:0] o_grant_idx,
   output logic          o_valid
);
   logic [IW-1:0] r_ptr;

   // Descending scan so the candidate closest to the pointer wins.
   always_comb begin
      o_valid     = 1'b0;
      o_grant_idx = '0;
      for (int k = NT - 1; k >= 0; k--) begin
         if (i_req[IW'((int'(r_ptr) + k) % NT)]) begin
            o_valid     = 1'b1;
            o_grant_idx = IW'((int'(r_ptr) + k) % NT);
         end
      end
      o_grant = o_valid ? (NT'(1) << o_grant_idx) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_advance && o_valid) begin
         r_ptr <= (o_grant_idx == IW'(NT - 1)) ? '0 : o_grant_idx + 1'b1;
      end
   end
endmodule

// File: rtl/zest_spi_sched.sv
// rtl/zest_spi_sched.sv - round-robin SPI frame sequencer for the Zest P2 config bus
// ZEST_SPI_LE_EN: target 0 framed by a uWire latch-enable pulse instead of chip select.
module zest_spi_sched
   import zest_spi_pkg::*;
#(
   parameter int NT      = 4,
   parameter int DIV     = 4,
   parameter int GAP     = 2,
   parameter int RD_BITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   zest_spi_sched_if.slave   host,
   output logic [NT-1:0]     csb,
   output logic              sclk,
   output logic              sdo,
   input  logic              sdi,
   output logic              sdio_as_i
);
   localparam int IW = (NT > 1) ? $clog2(NT) : 1;

   localparam logic [2:0] ST_IDLE  = zest_spi_pkg::IDLE;
   localparam logic [2:0] ST_SETUP = zest_spi_pkg::SETUP;
   localparam logic [2:0] ST_SHIFT = zest_spi_pkg::SHIFT;
   localparam logic [2:0] ST_HOLD  = zest_spi_pkg::HOLD;
   localparam logic [2:0] ST_GAP   = zest_spi_pkg::GAP;
`ifdef ZEST_SPI_LE_EN
   localparam logic [2:0] ST_LATCH = zest_spi_pkg::LATCH;
   localparam logic [NT-1:0] LE_MASK = NT'(1);
`else
   localparam logic [NT-1:0] LE_MASK = '0;
`endif
   // LE line on target 0 idles low; every real chip select idles high.
   localparam logic [NT-1:0] CSB_IDLE = ~LE_MASK;
   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
   localparam logic [5:0] RD_LEN   = 6'(RD_BITS);

   logic [2:0]         r_state;
   logic [7:0]         r_cnt;
   logic [IW-1:0]      r_id;
   logic               r_rd;
   logic [5:0]         r_bits;
   logic [30:0]        r_wdata;
   logic [RD_BITS-1:0] r_sr;
   logic [NT-1:0]      r_csb;
   logic               r_sclk;
   logic               r_sdo;
   logic               r_sdio;
   logic [NT-1:0]      r_ack;
   logic               r_done;
   logic [IW-1:0]      r_done_id;
   logic [RD_BITS-1:0] r_rdata;
   logic               r_busy;

   logic [NT-1:0] w_grant;
   logic [IW-1:0] w_gidx;
   logic          w_gvalid;
   logic          w_advance;
   logic [5:0]    w_len;
   logic          w_rd;
   logic [31:0]   w_wdata;
   logic          w_last;
   logic          w_rd_now;

   zest_rr_arb #(.NT(NT), .IW(IW)) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (host.req),
      .i_advance   (w_advance),
      .o_grant     (w_grant),
      .o_grant_idx (w_gidx),
      .o_valid     (w_gvalid)
   );

   assign w_advance = (r_state == ST_IDLE);
   assign w_len     = zest_spi_pkg::clamp_len(host.req_len[w_gidx*6 +: 6]);
   assign w_rd      = host.req_rd[w_gidx] & ~LE_MASK[w_gidx];
   assign w_wdata   = host.req_wdata[w_gidx*32 +: 32];
   assign w_last    = (r_cnt == DIV_LAST);
   // A read of exactly RD_BITS has no write phase: turn SDIO around at CSB fall.
   assign w_rd_now  = w_rd && (w_len == RD_LEN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_id      <= '0;
         r_rd      <= 1'b0;
         r_bits    <= '0;
         r_wdata   <= '0;
         r_sr      <= '0;
         r_csb     <= CSB_IDLE;
         r_sclk    <= 1'b0;
         r_sdo     <= 1'b0;
         r_sdio    <= 1'b0;
         r_ack     <= '0;
         r_done    <= 1'b0;
         r_done_id <= '0;
         r_rdata   <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_ack  <= '0;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_gvalid) begin
                  r_ack   <= w_grant;
                  r_id    <= w_gidx;
                  r_rd    <= w_rd;
                  r_bits  <= w_len;
                  r_wdata <= w_wdata[30:0];
                  r_csb   <= CSB_IDLE & ~(w_grant & ~LE_MASK);
                  r_sdio  <= w_rd_now;
                  r_sdo   <= w_wdata[31] & ~w_rd_now;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_last) begin
                  r_cnt   <= '0;
                  r_state <= ST_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     r_sr   <= {r_sr[RD_BITS-2:0], sdi};
                  end else begin
                     r_sclk  <= 1'b0;
                     r_bits  <= r_bits - 6'd1;
                     r_wdata <= {r_wdata[29:0], 1'b0};
                     if (r_bits == 6'd1) begin
                        r_sdo   <= 1'b0;
                        r_state <= ST_HOLD;
                     end else if (r_rd && ((r_bits - 6'd1) == RD_LEN)) begin
                        r_sdio <= 1'b1;
                        r_sdo  <= 1'b0;
                     end else begin
                        r_sdo <= r_wdata[30] & ~r_sdio;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt     <= '0;
                  r_csb     <= CSB_IDLE;
                  r_sdio    <= 1'b0;
                  r_done    <= 1'b1;
                  r_done_id <= r_id;
                  if (r_rd) r_rdata <= r_sr;
`ifdef ZEST_SPI_LE_EN
                  if (r_id == '0) begin
                     r_csb   <= CSB_IDLE | LE_MASK;
                     r_state <= ST_LATCH;
                  end else begin
                     r_state <= ST_GAP;
                  end
`else
                  r_state <= ST_GAP;
`endif
               end
            end
`ifdef ZEST_SPI_LE_EN
            ST_LATCH: begin
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt   <= '0;
                  r_csb   <= CSB_IDLE;
                  r_state <= ST_GAP;
               end
            end
`endif
            ST_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign host.ack     = r_ack;
   assign host.done    = r_done;
   assign host.done_id = r_done_id;
   assign host.rdata   = r_rdata;
   assign host.busy    = r_busy;
   assign csb          = r_csb;
   assign sclk         = r_sclk;
   assign sdo          = r_sdo;
   assign sdio_as_i    = r_sdio;
endmodule

// File: tb/tb_zest_spi_sched.sv
// tb/tb_zest_spi_sched.sv - directed self-checking bench for zest_spi_sched
module tb_zest_spi_sched;
   import zest_spi_pkg::*;

   localparam int NT = 4, DIV = 4, GAP = 2, RD_BITS = 8;
`ifdef ZEST_SPI_LE_EN
   localparam logic [3:0] CSB_IDLE = 4'b1110;
`else
   localparam logic [3:0] CSB_IDLE = 4'b1111;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sdi = 1'b0;
   logic [NT-1:0] csb;
   logic sclk, sdo, sdio_as_i;

   zest_spi_sched_if #(.NT(NT), .RD_BITS(RD_BITS)) host();

   zest_spi_sched #(.NT(NT), .DIV(DIV), .GAP(GAP), .RD_BITS(RD_BITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (host),
      .csb       (csb),
      .sclk      (sclk),
      .sdo       (sdo),
      .sdi       (sdi),
      .sdio_as_i (sdio_as_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int pulses, falls, done_cnt, multi_viol, sdo_viol, sdio_rise_at;
   int le_high, le_pulses, gap_run, min_gap;
   int ack_cnt [NT];
   int csb_low [NT];
   int order_q [$];
   logic [63:0] sdo_bits;
   logic [23:0] sdi_pat;
   logic [7:0]  last_rdata = '0;
   logic [1:0]  last_done_id = '0;
   logic sdio_at_done, seen_frame;
   logic prev_sclk = 1'b0, prev_sdio = 1'b0, prev_active = 1'b0, prev_le = 1'b0;

   always @(negedge clk) begin
      if (sclk && !prev_sclk) begin
         pulses++;
         sdo_bits = {sdo_bits[62:0], sdo};
         sdi_pat  = {sdi_pat[22:0], 1'b0};
         sdi      = sdi_pat[23];
      end
      if (!sclk && prev_sclk) falls++;
      if (sdio_as_i && !prev_sdio) sdio_rise_at = falls;
      if (sdio_as_i && sdo) sdo_viol++;
      for (int i = 0; i < NT; i++) begin
         if (!csb[i]) csb_low[i]++;
         if (host.ack[i]) begin
            ack_cnt[i]++;
            order_q.push_back(i);
            host.req[i] = 1'b0;
         end
      end
      if ($countones(~csb) > 1) multi_viol++;
      if ((csb != CSB_IDLE) && !prev_active) begin
         if (seen_frame && gap_run < min_gap) min_gap = gap_run;
         seen_frame = 1'b1;
      end
      if (csb != CSB_IDLE) gap_run = 0;
      else gap_run++;
      if (csb[0]) le_high++;
      if (csb[0] && !prev_le) le_pulses++;
      if (host.done) begin
         done_cnt++;
         last_done_id = host.done_id;
         last_rdata   = host.rdata;
         sdio_at_done = sdio_as_i;
      end
      prev_sclk   = sclk;
      prev_sdio   = sdio_as_i;
      prev_active = (csb != CSB_IDLE);
      prev_le     = csb[0];
   end

   task automatic clear_mon();
      pulses = 0; falls = 0; done_cnt = 0; multi_viol = 0; sdo_viol = 0;
      sdio_rise_at = 0; le_high = 0; le_pulses = 0; gap_run = 0; min_gap = 999;
      sdo_bits = '0; seen_frame = 1'b0; sdio_at_done = 1'b0;
      for (int i = 0; i < NT; i++) begin
         ack_cnt[i] = 0;
         csb_low[i] = 0;
      end
      order_q.delete();
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("done_seen", 64'(done_cnt), 64'(n));
   endtask

   task automatic run_frame(input int tgt, input logic rd, input logic [5:0] len,
                            input logic [31:0] wd, input logic [23:0] pat);
      @(posedge clk); #1;
      clear_mon();
      sdi_pat = pat;
      sdi     = pat[23];
      host.req_rd[tgt]           = rd;
      host.req_len[tgt*6 +: 6]   = len;
      host.req_wdata[tgt*32 +: 32] = wd;
      host.req[tgt]              = 1'b1;
      wait_done(1);
      repeat (GAP + 3) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] order_word();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++)
         v = {v[11:0], (i < order_q.size()) ? 4'(order_q[i]) : 4'hF};
      return v;
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      host.req = '0; host.req_rd = '0; host.req_len = '0; host.req_wdata = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_csb", 64'(csb), 64'(CSB_IDLE));
      check_eq("rst_sclk", 64'(sclk), 0);
      check_eq("rst_sdo", 64'(sdo), 0);
      check_eq("rst_sdio", 64'(sdio_as_i), 0);
      check_eq("rst_ack", 64'(host.ack), 0);
      check_eq("rst_done", 64'(host.done), 0);
      check_eq("rst_done_id", 64'(host.done_id), 0);
      check_eq("rst_rdata", 64'(host.rdata), 0);
      check_eq("rst_busy", 64'(host.busy), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_frame(TGT_U4, 1'b0, 6'd16, 32'hA5C3_0000, 24'h0);
      check_eq("wr_ack_cnt", 64'(ack_cnt[3]), 1);
      check_eq("wr_csb_low", 64'(csb_low[3]), 136);
      check_eq("wr_pulses", 64'(pulses), 16);
      check_eq("wr_sdo_bits", 64'(sdo_bits[15:0]), 64'h0000_0000_0000_A5C3);
      check_eq("wr_done_id", 64'(last_done_id), 3);
      check_eq("wr_busy_after", 64'(host.busy), 0);

      @(posedge clk); #1;
      clear_mon();
      for (int i = 0; i < NT; i++) begin
         host.req_rd[i] = 1'b0;
         host.req_len[i*6 +: 6] = 6'd8;
         host.req_wdata[i*32 +: 32] = 32'h1100_0000 * (i + 1);
      end
      host.req = 4'b1111;
      wait_done(4);
      repeat (GAP + 3) @(posedge clk);
      #1;
      check_eq("arb_order", 64'(order_word()), 64'h0123);
      check_eq("arb_one_csb", 64'(multi_viol), 0);
      check_eq("arb_min_gap", 64'(min_gap >= GAP), 1);

      run_frame(TGT_U2, 1'b1, 6'd24, 32'hFFFF_FF00, 24'h00005A);
      check_eq("rd_rdata", 64'(last_rdata), 64'h5A);
      check_eq("rd_done_id", 64'(last_done_id), 1);
      check_eq("rd_turn_fall", 64'(sdio_rise_at), 16);
      check_eq("rd_sdo_forced", 64'(sdo_viol), 0);
      check_eq("rd_sdio_at_done", 64'(sdio_at_done), 0);
      check_eq("rd_pulses", 64'(pulses), 24);

      run_frame(TGT_U3, 1'b0, 6'd40, 32'h1234_5678, 24'h0);
      check_eq("clamp_hi_pulses", 64'(pulses), 32);
      run_frame(TGT_U3, 1'b0, 6'd3, 32'h8765_4321, 24'h0);
      check_eq("clamp_lo_pulses", 64'(pulses), 8);
      check_eq("clamp_lo_csb_low", 64'(csb_low[2]), 72);

      @(posedge clk); #1;
      clear_mon();
      host.req_len[2*6 +: 6] = 6'd16;
      host.req[2] = 1'b1;
      for (int t = 0; t < 2000 && pulses < 10; t++) begin
         @(posedge clk); #1;
      end
      check_eq("rst_mid_reached", 64'(pulses), 10);
      host.req_len[1*6 +: 6] = 6'd8;
      host.req_len[3*6 +: 6] = 6'd8;
      host.req[1] = 1'b1;
      host.req[3] = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_csb", 64'(csb), 64'(CSB_IDLE));
      check_eq("abort_sclk", 64'(sclk), 0);
      check_eq("abort_busy", 64'(host.busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("abort_no_done", 64'(done_cnt), 0);
      order_q.delete();
      rst_n = 1'b1;
      wait_done(2);
      repeat (GAP + 3) @(posedge clk);
      #1;
      check_eq("post_rst_first", 64'(order_word()), 64'h13FF);

`ifdef ZEST_SPI_LE_EN
      run_frame(TGT_U1, 1'b0, 6'd32, 32'hDEAD_BEEF, 24'h0);
      check_eq("le_pulses", 64'(le_pulses), 1);
      check_eq("le_high_cycles", 64'(le_high), 64'(DIV));
      check_eq("le_sclk_pulses", 64'(pulses), 32);
      check_eq("le_done_id", 64'(last_done_id), 0);
      run_frame(TGT_U1, 1'b1, 6'd16, 32'h0000_0000, 24'hFFFFFF);
      check_eq("le_rd_rdata", 64'(last_rdata), 0);
      check_eq("le_rd_no_turn", 64'(sdio_rise_at), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
